// File: rtl/sillyfunction_pkg.sv
// Shared types and constants for the sillyfunction sweep engine.
// Holds the controller state encoding, the reference truth table and the fail-index helper.
package sillyfunction_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_t;

    localparam int unsigned NUM_VEC     = 8;
    localparam logic [7:0]  SILLY_TRUTH = 8'h31;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set3(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that flags expiry once it has counted down to zero.
// A load followed by Count-1 decrements yields exactly Count cycles before expiry is acted on.
module sweep_settle_timer #(
    parameter int unsigned Count = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam int unsigned Width = (Count > 1) ? $clog2(Count) : 1;
    localparam logic [Width-1:0] LoadVal = Width'(Count - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sillyfunction_sweeper.sv
// Sweep engine for the three-input sillyfunction: walks all eight input vectors,
// samples y after a settle delay, and compares the observed truth table with the expected one.
module sillyfunction_sweeper
    import sillyfunction_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = SILLY_TRUTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic [7:0] mismatch,
    output logic       pass,
    output logic       result_valid,
    output logic [2:0] fail_idx
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("sillyfunction_sweeper: SETTLE must be at least 1");
    end

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] truth_q, truth_d;
    logic       rv_q, rv_d;
    logic [2:0] fail_idx_q, fail_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic timer_load, timer_dec, timer_expired;

    sweep_settle_timer #(
        .Count(SETTLE)
    ) u_settle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (timer_load),
        .dec_i    (timer_dec),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        abc_d      = abc_q;
        truth_d    = truth_q;
        rv_d       = rv_q;
        fail_idx_d = fail_idx_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = StSettle;
                    idx_d      = 3'd0;
                    abc_d      = 3'd0;
                    truth_d    = 8'h00;
                    rv_d       = 1'b0;
                    timer_load = 1'b1;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    abc_d   = 3'd0;
                end else if (timer_expired) begin
                    state_d = StSample;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                    abc_d   = 3'd0;
                end else begin
                    truth_d[idx_q] = y;
                    if (idx_q == 3'(NUM_VEC - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        abc_d      = idx_q + 3'd1;
                        timer_load = 1'b1;
                        state_d    = StSettle;
                    end
                end
            end
            StDone: begin
                fail_idx_d = lowest_set3(truth_q ^ EXPECTED);
                // A start seen here chains straight into a new sweep without publishing results.
                if (start) begin
                    state_d    = StSettle;
                    idx_d      = 3'd0;
                    abc_d      = 3'd0;
                    truth_d    = 8'h00;
                    rv_d       = 1'b0;
                    timer_load = 1'b1;
                end else begin
                    state_d = StIdle;
                    rv_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            abc_q      <= 3'd0;
            truth_q    <= 8'h00;
            rv_q       <= 1'b0;
            fail_idx_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            abc_q      <= abc_d;
            truth_q    <= truth_d;
            rv_q       <= rv_d;
            fail_idx_q <= fail_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign {a, b, c}    = abc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth        = truth_q;
    assign result_valid = rv_q;
    assign fail_idx     = fail_idx_q;
    assign mismatch     = rv_q ? (truth_q ^ EXPECTED) : 8'h00;
    assign pass         = rv_q && (mismatch == 8'h00);

endmodule

// File: tb/tb_sillyfunction_sweeper.sv
// Bench for sillyfunction_sweeper: a LUT-driven stand-in for sillyfunction feeds y,
// and results are checked against tables derived directly from the LUT.
module tb_sillyfunction_sweeper;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned HOLD   = SETTLE + 1;
    localparam logic [7:0]  EXP    = 8'h31;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, y;
    logic       a, b, c, busy, done, pass, result_valid;
    logic [7:0] truth, mismatch;
    logic [2:0] fail_idx;
    logic [7:0] lut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Device under sweep: y is the LUT entry addressed by {a,b,c}.
    always_comb y = lut[{a, b, c}];

    sillyfunction_sweeper #(
        .SETTLE  (SETTLE),
        .EXPECTED(EXP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .y           (y),
        .a           (a),
        .b           (b),
        .c           (c),
        .busy        (busy),
        .done        (done),
        .truth       (truth),
        .mismatch    (mismatch),
        .pass        (pass),
        .result_valid(result_valid),
        .fail_idx    (fail_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_table(input logic [7:0] f);
        logic [7:0] t;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec  = 3'(v);
            t[v] = f[{vec[2], vec[1], vec[0]}];
        end
        return t;
    endfunction

    function automatic logic [2:0] ref_first(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".abc"}, 32'({a, b, c}), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".truth"}, 32'(truth), 32'd0);
        check({tag, ".mismatch"}, 32'(mismatch), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".rv"}, 32'(result_valid), 32'd0);
        check({tag, ".fail_idx"}, 32'(fail_idx), 32'd0);
    endtask

    // Runs one sweep. started: the start edge has already happened (chained sweep).
    // chain: hold start through the DONE cycle and return at the first cycle of the next sweep.
    task automatic do_sweep(input logic [7:0] f, input bit noise, input bit chain,
                            input bit started);
        logic [7:0] et, em;
        lut = f;
        if (!started) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        et = ref_table(f);
        em = et ^ EXP;
        for (int n = 0; n < int'(8 * HOLD); n++) begin
            check("sweep.abc", 32'({a, b, c}), 32'(n / int'(HOLD)));
            check("sweep.busy", 32'(busy), 32'd1);
            check("sweep.done", 32'(done), 32'd0);
            if (noise && n < int'(8 * HOLD) - 1) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        check("done.done", 32'(done), 32'd1);
        check("done.busy", 32'(busy), 32'd0);
        check("done.truth", 32'(truth), 32'(et));
        check("done.rv", 32'(result_valid), 32'd0);
        check("done.mismatch", 32'(mismatch), 32'd0);
        check("done.pass", 32'(pass), 32'd0);
        if (chain) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("chain.busy", 32'(busy), 32'd1);
            check("chain.done", 32'(done), 32'd0);
            check("chain.rv", 32'(result_valid), 32'd0);
            check("chain.truth", 32'(truth), 32'd0);
            check("chain.abc", 32'({a, b, c}), 32'd0);
            return;
        end
        tick();
        check("res.done", 32'(done), 32'd0);
        check("res.rv", 32'(result_valid), 32'd1);
        check("res.truth", 32'(truth), 32'(et));
        check("res.mismatch", 32'(mismatch), 32'(em));
        check("res.pass", 32'(pass), 32'(em == 8'h00));
        check("res.fail_idx", 32'(fail_idx), 32'(ref_first(em)));
        repeat (3) tick();
        check("hold.rv", 32'(result_valid), 32'd1);
        check("hold.truth", 32'(truth), 32'(et));
        check("hold.fail_idx", 32'(fail_idx), 32'(ref_first(em)));
        check("hold.busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        int         seen_done;

        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        lut     = EXP;
        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();
        check_reset_values("idle");

        // Correct function and the three fault models from the plan.
        do_sweep(8'h31, 1'b0, 1'b0, 1'b0);
        do_sweep(8'h00, 1'b0, 1'b0, 1'b0);
        do_sweep(8'hF0, 1'b0, 1'b0, 1'b0);
        do_sweep(8'h55, 1'b0, 1'b0, 1'b0);

        // Reset mid-sweep after a failing sweep left fail_idx nonzero.
        lut   = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        reset_n = 1'b0;
        tick();
        check_reset_values("midreset");
        reset_n   = 1'b1;
        seen_done = 0;
        repeat (30) begin
            tick();
            if (done) seen_done++;
        end
        check("midreset.no_done", 32'(seen_done), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);

        // Random functions, some with start noise while busy.
        for (int k = 0; k < 6; k++) begin
            r = 8'($urandom);
            do_sweep(r, bit'(k % 2), 1'b0, 1'b0);
        end

        // Abort sampled on the tenth edge after start.
        do_sweep(8'hF0, 1'b0, 1'b0, 1'b0);
        lut   = 8'hA7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.abc", 32'({a, b, c}), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.rv", 32'(result_valid), 32'd0);
        check("abort.truth", 32'(truth), 32'(ref_table(8'hA7) & 8'h07));
        seen_done = 0;
        repeat (30) begin
            tick();
            if (done) seen_done++;
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
        check("abort.hold_truth", 32'(truth), 32'(ref_table(8'hA7) & 8'h07));

        // start and abort together in idle: no sweep.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("startabort.busy", 32'(busy), 32'd0);
        tick();
        check("startabort.busy2", 32'(busy), 32'd0);

        // abort in idle is ignored and results hold.
        do_sweep(8'h31, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idleabort.rv", 32'(result_valid), 32'd1);
        check("idleabort.pass", 32'(pass), 32'd1);

        // Back-to-back sweeps via start held through DONE.
        do_sweep(8'h31, 1'b0, 1'b1, 1'b0);
        r = 8'($urandom);
        do_sweep(r, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed simulation still running, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sillyfunction_sweeper.md
Name: sillyfunction_sweeper

Overview:
Sequencing controller for the three-input sillyfunction datapath (inputs a, b, c; output y).
- Drives all 8 input vectors in ascending order, waits a programmable settle time per vector, and samples y.
- Assembles the observed 8-bit truth table and compares it against the expected table.
- Sits beside a sillyfunction instance as a self-checking sweep engine, for on-chip self-test and for bench reuse.

Parameters:
SETTLE, 2, cycles spent in SETTLE state per vector; must be >=1 (elaboration-time check, error if 0)
EXPECTED, 8'h31, expected truth table; bit i = y for {a,b,c}=i (minterms 000, 100, 101)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  sweep request, single-cycle or level; sampled only in IDLE or DONE
abort  in  1  cancel the sweep in progress
y  in  1  sillyfunction output
a  out  1  drive to sillyfunction a (MSB of vector index)
b  out  1  drive to sillyfunction b
c  out  1  drive to sillyfunction c (LSB)
busy  out  1  high in SETTLE/SAMPLE
done  out  1  one-cycle pulse when a sweep completes
truth  out  8  observed table, bit i = y sampled for vector i
mismatch  out  8  truth XOR EXPECTED, valid when result_valid
pass  out  1  result_valid && mismatch==0
result_valid  out  1  high from completion until next start, abort or reset
fail_idx  out  3  lowest set bit of mismatch; 0 when pass

Behaviour:
- One clock. Reset is synchronous and active-low on reset_n. All outputs are registered.
- Reset values:
  - state=IDLE, a/b/c=0, busy=0, done=0, truth=0, result_valid=0, fail_idx=0.
  - mismatch and pass are combinational from registers, so they reset to 0.
  - Reset mid-sweep has the same effect; no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> idx<=0, {a,b,c}<=000, truth<=0, result_valid<=0, cnt<=0, go to SETTLE.
- SETTLE:
  - If cnt==SETTLE-1, go to SAMPLE; otherwise cnt++.
- SAMPLE:
  - truth[idx]<=y.
  - If idx==7, go to DONE.
  - Otherwise idx++, {a,b,c}<=idx+1, cnt<=0, go to SETTLE.
- DONE:
  - done=1 for this cycle only; result_valid<=1; fail_idx updated.
  - start=1 in DONE -> behaves as a start from IDLE (back-to-back sweep; result_valid stays 0).
  - Otherwise go to IDLE.
- Timing:
  - {a,b,c} is stable for SETTLE+1 cycles before the sampling edge.
  - Sweep latency: start edge to DONE entry is 8*(SETTLE+1) cycles; done is asserted in the following cycle window.
- Index arithmetic: idx is 3 bits. Wrap 7->0 never occurs inside a sweep; exit happens at 7.
- abort:
  - Has priority over every transition except reset.
  - In SETTLE/SAMPLE: next state IDLE, {a,b,c}<=000, result_valid stays 0, truth holds its partial value, no done.
  - In IDLE/DONE: ignored.
  - start and abort together in IDLE: abort wins, no sweep starts.
- start while busy: ignored; no restart, no queueing.
- truth, fail_idx and result_valid hold in IDLE until the next accepted start.

Decomposition:
- Shared package sillyfunction_pkg holds:
  - state_t enum (IDLE, SETTLE, SAMPLE, DONE)
  - NUM_VEC=8
  - SILLY_TRUTH=8'h31 (default for EXPECTED)
  - function lowest_set3 (8-bit -> 3-bit index) used for fail_idx
- One natural sub-module: sweep_settle_timer.
  - Parameterised down-counter with load/expire.
  - Instantiated once for the SETTLE wait.

Test Plan:
- Real sillyfunction, SETTLE=2; start pulse at cycle 0:
  - abc walks 000..111, each held 3 cycles.
  - done pulses after 24 cycles.
  - truth=8'h31, mismatch=0, pass=1, fail_idx=0.
- Faulty model with y stuck at 0:
  - truth=8'h00, mismatch=8'h31, pass=0, fail_idx=0.
- Faulty model with y=a:
  - truth=8'hF0, mismatch=8'hC1, fail_idx=0.
- Faulty model with y=~c:
  - truth=8'h55, mismatch=8'h64, fail_idx=2.
- abort at cycle 10 (SETTLE=2):
  - next cycle busy=0, abc=000.
  - No done; result_valid=0; truth shows bits 0..2 only.
- Start pulses while busy are ignored (done still at cycle 24).
- start held through the DONE cycle: a second sweep starts immediately with result_valid=0 and truth cleared.
- reset_n low for 1 cycle mid-sweep: all outputs return to reset values on that edge, and no done follows.
